// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg timer: controller state encoding, BCD digit
// limits and a digit clamp used wherever presets are accepted.
package egg_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_COUNTING = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] val, input logic [3:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with a clamped parallel load; chained through
// borrow_in/borrow_out to build the MM:SS count.
module bcd_digit_down
    import egg_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] max,
    input  logic       borrow_in,
    input  logic       dec_en,
    input  logic       load_en,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       borrow_out
);

    logic [3:0] digit_r;

    // Digit register: load wins, otherwise step down only when the lower digit borrows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_r <= 4'd0;
        end else if (load_en) begin
            digit_r <= bcd_clamp(load_val, max);
        end else if (dec_en && borrow_in) begin
            digit_r <= (digit_r == 4'd0) ? max : (digit_r - 4'd1);
        end else begin
            digit_r <= digit_r;
        end
    end

    assign borrow_out = borrow_in && (digit_r == 4'd0);
    assign digit      = digit_r;

endmodule

// File: rtl/egg_timer_countdown.sv
// Egg timer countdown: latches a BCD MM:SS preset, counts down on 1 Hz ticks,
// then holds cook_time/alarm high for DONE_TICKS ticks before returning to idle.
module egg_timer_countdown
    import egg_timer_pkg::*;
#(
    parameter int unsigned DONE_TICKS = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_1hz,
    input  logic       enable_load,
    input  logic [3:0] load_second_ones,
    input  logic [3:0] load_second_tens,
    input  logic [3:0] load_minute_ones,
    input  logic [3:0] load_minute_tens,
    input  logic       enable_timer_countdown,
    output logic [3:0] second_ones,
    output logic [3:0] second_tens,
    output logic [3:0] minute_ones,
    output logic [3:0] minute_tens,
    output logic       running,
    output logic       cook_time,
    output logic       alarm
);

    localparam logic [3:0] DONE_LIMIT = 4'(DONE_TICKS);

    state_t     state_r, state_s;
    logic [3:0] done_cnt_r, done_cnt_s;
    logic [3:0] done_inc_s;
    logic       running_r, cook_time_r, alarm_r;
    logic       active_s, count_s, zero_s, last_s, dec_en_s;
    logic       borrow_so_s, borrow_st_s, borrow_mo_s, borrow_mt_s;

    assign active_s   = (state_r == ST_ARMED) || (state_r == ST_COUNTING);
    assign count_s    = active_s && tick_1hz && enable_timer_countdown;
    assign zero_s     = (minute_tens == 4'd0) && (minute_ones == 4'd0) &&
                        (second_tens == 4'd0) && (second_ones == 4'd0);
    // 00:01 is the last non-zero count: its decrement lands in DONE on the same edge.
    assign last_s     = (minute_tens == 4'd0) && (minute_ones == 4'd0) &&
                        (second_tens == 4'd0) && (second_ones == 4'd1);
    assign dec_en_s   = count_s && !enable_load && !zero_s;
    assign done_inc_s = done_cnt_r + 4'd1;

    bcd_digit_down u_second_ones (
        .clk(clk), .reset_n(reset_n), .max(ONES_MAX), .borrow_in(1'b1),
        .dec_en(dec_en_s), .load_en(enable_load), .load_val(load_second_ones),
        .digit(second_ones), .borrow_out(borrow_so_s)
    );

    bcd_digit_down u_second_tens (
        .clk(clk), .reset_n(reset_n), .max(TENS_MAX), .borrow_in(borrow_so_s),
        .dec_en(dec_en_s), .load_en(enable_load), .load_val(load_second_tens),
        .digit(second_tens), .borrow_out(borrow_st_s)
    );

    bcd_digit_down u_minute_ones (
        .clk(clk), .reset_n(reset_n), .max(ONES_MAX), .borrow_in(borrow_st_s),
        .dec_en(dec_en_s), .load_en(enable_load), .load_val(load_minute_ones),
        .digit(minute_ones), .borrow_out(borrow_mo_s)
    );

    bcd_digit_down u_minute_tens (
        .clk(clk), .reset_n(reset_n), .max(TENS_MAX), .borrow_in(borrow_mo_s),
        .dec_en(dec_en_s), .load_en(enable_load), .load_val(load_minute_tens),
        .digit(minute_tens), .borrow_out(borrow_mt_s)
    );

    // Next-state and DONE tick counter; a load overrides everything else.
    always_comb begin
        state_s    = state_r;
        done_cnt_s = done_cnt_r;
        if (enable_load) begin
            state_s    = ST_ARMED;
            done_cnt_s = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_ARMED, ST_COUNTING: begin
                    if (count_s) begin
                        if (zero_s || last_s) begin
                            state_s    = ST_DONE;
                            done_cnt_s = 4'd0;
                        end else begin
                            state_s = ST_COUNTING;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_DONE: begin
                    if (tick_1hz) begin
                        if (done_inc_s >= DONE_LIMIT) begin
                            state_s    = ST_IDLE;
                            done_cnt_s = 4'd0;
                        end else begin
                            done_cnt_s = done_inc_s;
                        end
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s    = ST_IDLE;
                    done_cnt_s = 4'd0;
                end
            endcase
        end
    end

    // State, counter and status flags, all decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            done_cnt_r  <= 4'd0;
            running_r   <= 1'b0;
            cook_time_r <= 1'b0;
            alarm_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            done_cnt_r  <= done_cnt_s;
            running_r   <= (state_s == ST_COUNTING);
            cook_time_r <= (state_s == ST_DONE);
            alarm_r     <= (state_s == ST_DONE);
        end
    end

    assign running   = running_r;
    assign cook_time = cook_time_r;
    assign alarm     = alarm_r;

endmodule

// File: doc/egg_timer_countdown.md
Name: egg_timer_countdown

Overview:
- Consumer end of the egg timer control interface.
- Latches the BCD MM:SS preset presented by the timer control FSM on enable_load, then counts down once per 1 Hz tick while enable_timer_countdown is high.
- Returns cook_time to the control FSM at 00:00 and drives the digits to the BCD display mux.
- Runs on the system clock; the 1 Hz tick from the clock divider is used as a single-cycle enable.

Parameters:
- DONE_TICKS, 5, number of 1 Hz ticks cook_time/alarm stay asserted after reaching 00:00 (legal range 1..15).

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  one-clk-wide strobe, once per second, synchronous to clk.
- enable_load  in  1  latch the load_* digits this cycle.
- load_second_ones  in  4  preset, BCD 0..9.
- load_second_tens  in  4  preset, BCD 0..5.
- load_minute_ones  in  4  preset, BCD 0..9.
- load_minute_tens  in  4  preset, BCD 0..5.
- enable_timer_countdown  in  1  countdown permitted; low means pause.
- second_ones  out  4  current count, BCD.
- second_tens  out  4  current count, BCD.
- minute_ones  out  4  current count, BCD.
- minute_tens  out  4  current count, BCD.
- running  out  1  high in the COUNTING state.
- cook_time  out  1  high in the DONE state; feeds the control FSM.
- alarm  out  1  buzzer/LED drive; equal to cook_time, registered.

Behaviour:
- Reset (async, reset_n=0): all digits 0, state IDLE; running, cook_time and alarm all 0. Recovery is synchronous on the first clk edge after reset_n rises.
- All outputs are registered. Every transition is on a clk rising edge.
- States: IDLE, ARMED, COUNTING, DONE.
- enable_load=1 in any state:
  - Latch digits, go to ARMED, clear the DONE tick counter.
  - cook_time and alarm are 0 from the next cycle.
  - Load has priority over a coincident tick. No decrement happens that cycle.
- Load sanitising: a ones digit >9 loads as 9; a tens digit >5 loads as 5. Maximum count is 59:59.
- ARMED or COUNTING, tick_1hz=1 and enable_timer_countdown=1:
  - If the count is 00:00, go to DONE; the digits stay 0.
  - Otherwise decrement by one second and go to (or stay in) COUNTING.
- When a decrement produces 00:00, the state goes to DONE on the same edge. cook_time is therefore high in the cycle after the last digit change, with no extra tick.
- Decrement borrow chain:
  - second_ones 0 becomes 9 with a borrow; otherwise it decrements by 1.
  - second_tens 0 becomes 5 with a borrow; otherwise it decrements by 1.
  - minute_ones 0 becomes 9 with a borrow; otherwise it decrements by 1.
  - minute_tens decrements on a borrow. It never underflows, because 00:00 is caught first.
- enable_timer_countdown=0 in ARMED or COUNTING: hold the count and the state. Ticks are ignored (pause).
- tick_1hz=0: no change.
- IDLE: ticks are ignored; only enable_load leaves IDLE.
- DONE:
  - cook_time=1 and alarm=1.
  - A 4-bit counter increments on each tick, independent of enable_timer_countdown.
  - When the counter reaches DONE_TICKS, go to IDLE and clear cook_time and alarm on the same edge.
- Reset asserted mid-count or in DONE aborts immediately to the reset values.
- The load_* inputs are sampled only when enable_load=1.

Decomposition:
- Shared package egg_timer_pkg holds:
  - state encoding localparams (2 bits);
  - BCD limit constants ONES_MAX=9, TENS_MAX=5.
- These are shared with the control FSM's up-count helper.
- One natural sub-module, bcd_digit_down: a single digit with inputs max, borrow_in, dec_en, load_en and load_val, and outputs digit and borrow_out. It is instantiated four times and chained.
- The top level holds the state machine and the DONE counter.

Test Plan:
- Reset: hold reset_n=0 mid-count at 01:30 -> digits 00:00, IDLE, running=0, cook_time=0, asynchronously before the next edge.
- Load 01:00, enable countdown, one tick -> 00:59; second tick -> 00:58; running=1 from the first tick.
- Load 00:02, two ticks -> 00:01, then 00:00 with cook_time=1 the next clk. alarm stays high for exactly 5 ticks (DONE_TICKS=5), then IDLE with cook_time=0.
- Borrow: load 10:00, one tick -> 09:59. Load 59:59 -> counts 59:58.
- Pause and priority:
  - Load 00:10, tick with enable_timer_countdown=0 -> stays 00:10.
  - enable_load with load 00:05 coincident with a tick -> 00:05, no decrement.
- Load 00:00, then a tick -> DONE, cook_time=1. Load 7F:AB (invalid digits) -> sanitised to 59:59.
